ysyx_25020047_mem_arbiter: RTL and testbench
============================================

// Module: ysyx_25020047_mem_arbiter
// PURPOSE
//  Shares the single pmem port between the IFU (fetch) and LSU (load/store) for the
//  multi-cycle NPC core. Two-way round-robin arbiter + one-outstanding transaction
//  sequencer with request latching, response routing and a response-timeout watchdog.
//  Sits between IFU/LSU and the pmem bridge; owns all ordering between fetch and data.
// PARAMETERS
//  AW       32   address width
//  DW       32   data width
//  TIMEOUT  255  max cycles in WAIT before a synthetic error response (>=1)
// PORTS
//  clk            in   1     core clock, all state on rising edge
//  rst            in   1     asynchronous, active-low reset
//  ifu_req_valid  in   1     IFU fetch request
//  ifu_req_ready  out  1     IFU request accepted this cycle
//  ifu_addr       in   AW    fetch address
//  ifu_resp_valid out  1     one-cycle pulse: fetch data valid
//  ifu_rdata      out  DW    fetched instruction
//  ifu_resp_err   out  1     access error / timeout (qualified by resp_valid)
//  lsu_req_valid  in   1     LSU request
//  lsu_req_ready  out  1     LSU request accepted this cycle
//  lsu_addr       in   AW    load/store address
//  lsu_wen        in   1     1=store, 0=load
//  lsu_wdata      in   DW    store data
//  lsu_wmask      in   DW/8  store byte mask
//  lsu_resp_valid out  1     one-cycle pulse: load data / store done
//  lsu_rdata      out  DW    load data (0 for stores)
//  lsu_resp_err   out  1     access error / timeout
//  mem_req_valid  out  1     request to pmem bridge
//  mem_req_ready  in   1     bridge accepts request
//  mem_addr/mem_wen/mem_wdata/mem_wmask  out  AW/1/DW/DW/8  latched request fields
//  mem_resp_valid in   1     bridge response pulse
//  mem_rdata      in   DW    response data
//  mem_resp_err   in   1     response error
// BEHAVIOUR
//  - Reset (async, rst=0): state=IDLE, last_grant=IFU, all *_valid/*_ready/err=0,
//    rdata=0, latched request regs=0, timeout counter=0.
//  - States: IDLE -> REQ -> WAIT -> IDLE; WAIT -(timeout)-> DRAIN -> IDLE.
//  - IDLE: *_req_ready asserted combinationally only for the round-robin winner among
//    valid requesters; only one requester, or winner = the one NOT last granted.
//    Handshake (valid&ready) latches addr/wen/wdata/wmask/owner, goes REQ next cycle.
//    Requester fields need only be stable in the accept cycle.
//  - REQ: mem_req_valid=1 with latched fields, held stable until mem_req_ready; then WAIT.
//    No timeout in REQ.
//  - WAIT: counter increments each cycle. On mem_resp_valid in cycle W: owner
//    resp_valid=1 at W+1 (registered) with rdata/err; last_grant<=owner; IDLE at W+1.
//    If counter reaches TIMEOUT first: owner resp_valid=1, err=1, rdata=0, go DRAIN.
//  - DRAIN: discard the next mem_resp_valid, then IDLE. No req_ready in DRAIN.
//  - Min latency accept->resp with zero-wait bridge (ready=1, resp next cycle): 3 cycles.
//  - Exactly one transaction outstanding; resp_valid never asserted for non-owner;
//    requesters must always accept responses (no resp_ready).
//  - mem_resp_valid in IDLE/REQ: ignored (protocol violation, no state change).
//  - lsu_rdata forced 0 when the latched wen=1.
//  - New accept allowed in same cycle resp_valid pulses (state already IDLE).
//  - Reset mid-transaction: abort immediately, no response issued, return to IDLE.
// STRUCTURE
//  - Shared header ysyx_25020047_defs: state encodings (IDLE/REQ/WAIT/DRAIN),
//    requester IDs (REQ_IFU=0, REQ_LSU=1).
//  - Sub-module ysyx_25020047_rr_arb2: 2-way round-robin picker (req[1:0], last -> gnt).
//  - Top: FSM, request latch, timeout counter, response mux/registers.
// TESTING
//  1 IFU alone, addr=0x8000_0000, bridge ready=1, rdata=0x0000_0413 next cycle ->
//    ifu_resp_valid 1 cycle, rdata=0x0000_0413, err=0, latency 3 cycles.
//  2 IFU+LSU valid same cycle after reset -> LSU granted first (last=IFU), IFU next;
//    repeat both held -> strict alternation LSU,IFU,LSU,IFU.
//  3 LSU store addr=0x8000_1000 wdata=0xDEAD_BEEF wmask=0xF, bridge ready delayed 4
//    cycles -> mem fields stable all 4 cycles, lsu_resp_valid with rdata=0.
//  4 Bridge never responds, TIMEOUT=8 -> err response 8 cycles into WAIT, rdata=0;
//    late mem_resp_valid dropped in DRAIN; following IFU request served normally.
//  5 Assert rst=0 during WAIT -> all outputs 0 asynchronously, no resp pulse after release.
//  6 mem_resp_err=1 on LSU load -> lsu_resp_err=1, ifu_resp_valid stays 0.

Source files
------------

// File: rtl/ysyx_25020047_mem_arbiter_pkg.sv
// rtl/ysyx_25020047_mem_arbiter_pkg.sv - shared state encodings and requester IDs
package ysyx_25020047_defs;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic REQ_IFU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

endpackage

// File: rtl/ysyx_25020047_rr_arb2.sv
// rtl/ysyx_25020047_rr_arb2.sv - two-way round-robin picker (bit0 IFU, bit1 LSU)
module ysyx_25020047_rr_arb2
  import ysyx_25020047_defs::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // On contention the requester not served last time wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last == REQ_LSU) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ysyx_25020047_mem_arbiter.sv
// rtl/ysyx_25020047_mem_arbiter.sv - IFU/LSU arbiter and single-outstanding pmem sequencer
module ysyx_25020047_mem_arbiter
  import ysyx_25020047_defs::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_addr,
  output logic            ifu_resp_valid,
  output logic [DW-1:0]   ifu_rdata,
  output logic            ifu_resp_err,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [AW-1:0]   lsu_addr,
  input  logic            lsu_wen,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wmask,
  output logic            lsu_resp_valid,
  output logic [DW-1:0]   lsu_rdata,
  output logic            lsu_resp_err,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_resp_valid,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_resp_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state, state_nxt;
  logic          last_grant;
  logic          owner;
  logic [CW-1:0] cnt;
  logic [1:0]    gnt;
  logic          accept;
  logic          resp_hit;
  logic          timeout_hit;
  logic [DW-1:0] resp_data;
  logic          resp_err;

  ysyx_25020047_rr_arb2 u_rr_arb2 (
    .req  ({lsu_req_valid, ifu_req_valid}),
    .last (last_grant),
    .gnt  (gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Readies are gated by reset so nothing is accepted while held in reset.
  always_comb begin
    state_nxt     = state;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    accept        = 1'b0;
    resp_hit      = 1'b0;
    timeout_hit   = 1'b0;
    case (state)
      S_IDLE: begin
        ifu_req_ready = rst & gnt[0];
        lsu_req_ready = rst & gnt[1];
        accept        = (ifu_req_valid & ifu_req_ready) | (lsu_req_valid & lsu_req_ready);
        if (accept) state_nxt = S_REQ;
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          resp_hit  = 1'b1;
          state_nxt = S_IDLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_nxt   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_resp_valid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign resp_data = timeout_hit ? '0 : mem_rdata;
  assign resp_err  = timeout_hit | mem_resp_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant     <= REQ_IFU;
      owner          <= REQ_IFU;
      cnt            <= '0;
      mem_addr       <= '0;
      mem_wen        <= 1'b0;
      mem_wdata      <= '0;
      mem_wmask      <= '0;
      ifu_resp_valid <= 1'b0;
      ifu_rdata      <= '0;
      ifu_resp_err   <= 1'b0;
      lsu_resp_valid <= 1'b0;
      lsu_rdata      <= '0;
      lsu_resp_err   <= 1'b0;
    end else begin
      ifu_resp_valid <= 1'b0;
      ifu_resp_err   <= 1'b0;
      lsu_resp_valid <= 1'b0;
      lsu_resp_err   <= 1'b0;

      if (accept) begin
        if (gnt[1]) begin
          owner     <= REQ_LSU;
          mem_addr  <= lsu_addr;
          mem_wen   <= lsu_wen;
          mem_wdata <= lsu_wdata;
          mem_wmask <= lsu_wmask;
        end else begin
          owner     <= REQ_IFU;
          mem_addr  <= ifu_addr;
          mem_wen   <= 1'b0;
          mem_wdata <= '0;
          mem_wmask <= '0;
        end
      end

      if (state == S_REQ) begin
        cnt <= '0;
      end else if (state == S_WAIT) begin
        cnt <= cnt + CW'(1);
      end

      if (resp_hit || timeout_hit) begin
        if (owner == REQ_IFU) begin
          ifu_resp_valid <= 1'b1;
          ifu_rdata      <= resp_data;
          ifu_resp_err   <= resp_err;
        end else begin
          lsu_resp_valid <= 1'b1;
          lsu_rdata      <= mem_wen ? '0 : resp_data;
          lsu_resp_err   <= resp_err;
        end
      end

      if (resp_hit) last_grant <= owner;
    end
  end

endmodule

// File: tb/tb_ysyx_25020047_mem_arbiter.sv
// tb/tb_ysyx_25020047_mem_arbiter.sv - directed self-checking bench for the pmem arbiter
module tb_ysyx_25020047_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;
  logic        ifu_resp_err;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;
  logic        lsu_resp_err;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        mem_resp_err;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_25020047_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge, outputs are sampled 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b0;
    ifu_req_valid = 0; ifu_addr = 0;
    lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0; mem_resp_err = 0;
    cyc(); cyc();
    settle();
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_ifu_resp_valid", 32'(ifu_resp_valid), 32'd0);
    check("rst_lsu_rdata", lsu_rdata, 32'd0);
    rst = 1'b1;
    cyc();

    // 1: lone IFU fetch, zero-wait bridge, 3-cycle latency
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
    settle();
    check("t1_ifu_ready", 32'(ifu_req_ready), 32'd1);
    check("t1_lsu_ready", 32'(lsu_req_ready), 32'd0);
    cyc();
    ifu_req_valid = 0; ifu_addr = 32'h1111_1111; mem_req_ready = 1;
    settle();
    check("t1_mem_req_valid", 32'(mem_req_valid), 32'd1);
    check("t1_mem_addr", mem_addr, 32'h8000_0000);
    check("t1_mem_wen", 32'(mem_wen), 32'd0);
    cyc();
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0000_0413;
    settle();
    check("t1_resp_early", 32'(ifu_resp_valid), 32'd0);
    cyc();
    mem_resp_valid = 0; mem_rdata = 0;
    settle();
    check("t1_resp_valid", 32'(ifu_resp_valid), 32'd1);
    check("t1_rdata", ifu_rdata, 32'h0000_0413);
    check("t1_err", 32'(ifu_resp_err), 32'd0);
    check("t1_lsu_no_resp", 32'(lsu_resp_valid), 32'd0);
    cyc();
    settle();
    check("t1_pulse_one_cycle", 32'(ifu_resp_valid), 32'd0);

    // 2: contention, strict alternation starting with LSU
    ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
    lsu_req_valid = 1; lsu_addr = 32'h8000_2000; lsu_wen = 0;
    settle();
    for (int i = 0; i < 4; i++) begin
      logic exp_lsu;
      exp_lsu = (i % 2 == 0);
      check($sformatf("t2_lsu_ready_%0d", i), 32'(lsu_req_ready), 32'(exp_lsu));
      check($sformatf("t2_ifu_ready_%0d", i), 32'(ifu_req_ready), 32'(!exp_lsu));
      cyc();
      mem_req_ready = 1;
      settle();
      check($sformatf("t2_mem_addr_%0d", i), mem_addr, exp_lsu ? 32'h8000_2000 : 32'h8000_0004);
      cyc();
      mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h1000 + 32'(i);
      cyc();
      mem_resp_valid = 0;
      settle();
      check($sformatf("t2_lsu_resp_%0d", i), 32'(lsu_resp_valid), 32'(exp_lsu));
      check($sformatf("t2_ifu_resp_%0d", i), 32'(ifu_resp_valid), 32'(!exp_lsu));
      check($sformatf("t2_rdata_%0d", i), exp_lsu ? lsu_rdata : ifu_rdata, 32'h1000 + 32'(i));
    end
    ifu_req_valid = 0; lsu_req_valid = 0;
    cyc();

    // 3: LSU store with bridge ready delayed 4 cycles
    lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    settle();
    check("t3_lsu_ready", 32'(lsu_req_ready), 32'd1);
    cyc();
    lsu_req_valid = 0; lsu_addr = 32'h0; lsu_wen = 0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
    for (int k = 0; k < 4; k++) begin
      settle();
      check($sformatf("t3_valid_%0d", k), 32'(mem_req_valid), 32'd1);
      check($sformatf("t3_addr_%0d", k), mem_addr, 32'h8000_1000);
      check($sformatf("t3_wdata_%0d", k), mem_wdata, 32'hDEAD_BEEF);
      check($sformatf("t3_wmask_wen_%0d", k), {27'd0, mem_wen, mem_wmask}, 32'h1F);
      cyc();
    end
    mem_req_ready = 1;
    cyc();
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h1234_5678;
    cyc();
    mem_resp_valid = 0;
    settle();
    check("t3_resp_valid", 32'(lsu_resp_valid), 32'd1);
    check("t3_store_rdata_zero", lsu_rdata, 32'd0);
    cyc();

    // 4: bridge never answers, timeout after 8 WAIT cycles, late response drained
    ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
    cyc();
    ifu_req_valid = 0; mem_req_ready = 1;
    cyc();
    mem_req_ready = 0;
    for (int k = 0; k < 8; k++) begin
      settle();
      check($sformatf("t4_no_resp_%0d", k), 32'(ifu_resp_valid), 32'd0);
      cyc();
    end
    ifu_req_valid = 1; ifu_addr = 32'h8000_0200;
    settle();
    check("t4_timeout_valid", 32'(ifu_resp_valid), 32'd1);
    check("t4_timeout_err", 32'(ifu_resp_err), 32'd1);
    check("t4_timeout_rdata", ifu_rdata, 32'd0);
    check("t4_drain_no_ready", 32'(ifu_req_ready), 32'd0);
    mem_resp_valid = 1; mem_rdata = 32'h0000_0BAD;
    cyc();
    mem_resp_valid = 0;
    settle();
    check("t4_late_dropped", 32'(ifu_resp_valid), 32'd0);
    check("t4_idle_ready", 32'(ifu_req_ready), 32'd1);
    cyc();
    ifu_req_valid = 0; mem_req_ready = 1;
    settle();
    check("t4_next_addr", mem_addr, 32'h8000_0200);
    cyc();
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0010_0073;
    cyc();
    mem_resp_valid = 0;
    settle();
    check("t4_next_valid", 32'(ifu_resp_valid), 32'd1);
    check("t4_next_rdata", ifu_rdata, 32'h0010_0073);
    check("t4_next_err", 32'(ifu_resp_err), 32'd0);
    cyc();

    // 5: reset asserted while waiting for the bridge
    lsu_req_valid = 1; lsu_addr = 32'h8000_3300; lsu_wen = 0;
    cyc();
    lsu_req_valid = 0; mem_req_ready = 1;
    cyc();
    mem_req_ready = 0; ifu_req_valid = 1; mem_resp_valid = 1; mem_rdata = 32'h7777_7777;
    rst = 1'b0;
    settle();
    check("t5_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("t5_mem_addr", mem_addr, 32'd0);
    check("t5_ifu_ready", 32'(ifu_req_ready), 32'd0);
    check("t5_ifu_rdata", ifu_rdata, 32'd0);
    cyc();
    ifu_req_valid = 0;
    rst = 1'b1;
    cyc();
    mem_resp_valid = 0;
    settle();
    check("t5_no_lsu_resp_a", 32'(lsu_resp_valid), 32'd0);
    check("t5_idle_mem_req", 32'(mem_req_valid), 32'd0);
    cyc();
    settle();
    check("t5_no_lsu_resp_b", 32'(lsu_resp_valid), 32'd0);

    // 6: bridge error on LSU load goes to LSU only
    lsu_req_valid = 1; lsu_addr = 32'h8000_3000; lsu_wen = 0;
    cyc();
    lsu_req_valid = 0; mem_req_ready = 1;
    cyc();
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_err = 1; mem_rdata = 32'h0000_0055;
    cyc();
    mem_resp_valid = 0; mem_resp_err = 0;
    settle();
    check("t6_lsu_valid", 32'(lsu_resp_valid), 32'd1);
    check("t6_lsu_err", 32'(lsu_resp_err), 32'd1);
    check("t6_ifu_quiet", 32'(ifu_resp_valid), 32'd0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
